mcc_word_sequencer: RTL and testbench
=====================================

// Module: mcc_word_sequencer
// PURPOSE
//  Drives the registered 5-bit MCC adder stage (input dff bank -> mcc_1bit chain -> output dff bank)
//  as a slice engine for wide adds. Accepts a SLICES*SLICE_W-bit operand pair with a valid/ready handshake.
//  Issues one 5-bit slice at a time to the adder, LSB slice first, and feeds each slice's carry-out back as
//  the next slice's carry-in. Collects the registered slice sums into a wide result for a valid/ready consumer.
// PARAMETERS
//  SLICES   4  number of 5-bit slices per operation (result width W = SLICES*SLICE_W = 20)
//  SLICE_W  5  slice width; fixed by the MCC adder stage
//  ADD_LAT  2  cycles from slice presented on add_a/add_b/add_cin to valid add_sum/add_cout (in dff + out dff)
// PORTS
//  clk        in   1        system clock, rising edge; the adder stage runs on the same clk
//  rst_n      in   1        asynchronous, active-low reset
//  in_valid   in   1        operand request valid
//  in_ready   out  1        block can accept a request (high only in IDLE)
//  op_a       in   W        operand A
//  op_b       in   W        operand B
//  op_cin     in   1        carry-in to slice 0
//  add_a      out  SLICE_W  slice of A driven to the adder's A input
//  add_b      out  SLICE_W  slice of B driven to the adder's B input
//  add_cin    out  1        slice carry-in driven to the adder's Cin input
//  add_sum    in   SLICE_W  registered SUM from the adder
//  add_cout   in   1        registered Cout from the adder
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts the result
//  out_sum    out  W        wide sum
//  out_cout   out  1        final carry-out (of slice SLICES-1)
//  busy       out  1        high in EXEC or DONE
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; add_a/add_b/add_cin/out_sum/out_cout/out_valid/busy=0; in_ready=1.
//    Assertion mid-operation aborts immediately. No partial result is retained.
//  - All outputs except in_ready come from registers. in_ready = (state==IDLE).
//  - FSM states: IDLE, EXEC, DONE.
//    - IDLE: add_* driven 0. On in_valid&&in_ready:
//      - latch op_a/op_b; idx<=0; wcnt<=0; carry<=op_cin.
//      - drive slice 0 (add_a=op_a[4:0], add_b=op_b[4:0], add_cin=op_cin).
//      - go to EXEC.
//    - EXEC: add_a/add_b/add_cin held stable while wcnt counts 0..ADD_LAT.
//      - At the edge with wcnt==ADD_LAT: out_sum[idx*5+:5]<=add_sum; carry<=add_cout.
//      - If idx<SLICES-1: idx++, wcnt<=0, drive slice idx+1 with add_cin=add_cout (sampled same edge).
//      - If idx==SLICES-1: out_cout<=add_cout, out_valid<=1, add_*<=0, go to DONE.
//    - DONE: out_valid=1; out_sum/out_cout held stable. On out_ready=1, out_valid<=0 and go to IDLE at that edge.
//  - Latency: SLICES*(ADD_LAT+1) edges from the accept edge to out_valid=1. The default is 12.
//  - No back-to-back operations: earliest next accept is the edge after DONE exits (in_ready is high in IDLE only).
//  - in_valid outside IDLE is ignored; op_a/op_b/op_cin changes after the accept edge have no effect.
//  - out_sum is written only by slice captures. Slices are overwritten during the next operation.
//  - Arithmetic is unsigned modulo 2^W; out_cout is bit W of op_a+op_b+op_cin.
// TESTING
//  Bench: real dff/mcc_1bit stage as the adder, SLICES=4, ADD_LAT=2, 10-unit clock.
//  1. Hold rst_n=0 for 3 cycles -> all outputs 0, in_ready=1; release -> still idle, add_*=0.
//  2. op_a=1, op_b=2, op_cin=0 -> out_valid exactly 12 edges after accept, out_sum=0x00003, out_cout=0.
//  3. op_a=0xFFFFF, op_b=0x00001, op_cin=0 -> out_sum=0x00000, out_cout=1 (carry through all 4 slices).
//  4. op_a=0x12345, op_b=0x0ABCD, op_cin=1 -> out_sum=0x1CF13, out_cout=0;
//     add_a/add_b/add_cin stable for 3 cycles per slice.
//  5. out_ready=0 for 5 cycles in DONE -> out_valid and out_sum stable; in_valid pulses ignored;
//     out_ready=1 -> in_ready=1 next cycle.
//  6. rst_n=0 during slice 2 of test 4 -> immediate zeros; after release, test 3 repeats with the correct result.

Source files
------------

// File: rtl/mcc_word_sequencer.sv
// rtl/mcc_word_sequencer.sv - slices a wide add across the registered 5-bit MCC adder stage
module mcc_word_sequencer #(
    parameter int SLICES  = 4,
    parameter int SLICE_W = 5,
    parameter int ADD_LAT = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SLICES*SLICE_W-1:0]   op_a,
    input  logic [SLICES*SLICE_W-1:0]   op_b,
    input  logic                        op_cin,
    output logic [SLICE_W-1:0]          add_a,
    output logic [SLICE_W-1:0]          add_b,
    output logic                        add_cin,
    input  logic [SLICE_W-1:0]          add_sum,
    input  logic                        add_cout,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SLICES*SLICE_W-1:0]   out_sum,
    output logic                        out_cout,
    output logic                        busy
);
    localparam int W     = SLICES * SLICE_W;
    localparam int IDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int WC_W  = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SLICES - 1);
    localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(ADD_LAT);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [WC_W-1:0]    wcnt;
    logic [W-1:0]       opa_q;
    logic [W-1:0]       opb_q;

    assign in_ready = (state == IDLE);

    // Operand registers shift right so the next slice to issue always sits in the low bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            wcnt      <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            add_a     <= '0;
            add_b     <= '0;
            add_cin   <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa_q   <= op_a >> SLICE_W;
                        opb_q   <= op_b >> SLICE_W;
                        add_a   <= op_a[SLICE_W-1:0];
                        add_b   <= op_b[SLICE_W-1:0];
                        add_cin <= op_cin;
                        idx     <= '0;
                        wcnt    <= '0;
                        busy    <= 1'b1;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (wcnt == WC_LAST) begin
                        for (int s = 0; s < SLICES; s++) begin
                            if (idx == IDX_W'(s)) begin
                                out_sum[s*SLICE_W +: SLICE_W] <= add_sum;
                            end
                        end
                        wcnt <= '0;
                        if (idx == IDX_LAST) begin
                            out_cout  <= add_cout;
                            out_valid <= 1'b1;
                            add_a     <= '0;
                            add_b     <= '0;
                            add_cin   <= 1'b0;
                            state     <= DONE;
                        end else begin
                            idx     <= idx + 1'b1;
                            add_a   <= opa_q[SLICE_W-1:0];
                            add_b   <= opb_q[SLICE_W-1:0];
                            add_cin <= add_cout;
                            opa_q   <= opa_q >> SLICE_W;
                            opb_q   <= opb_q >> SLICE_W;
                        end
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mcc_word_sequencer.sv
// tb/tb_mcc_word_sequencer.sv - randomized and directed bench with a two-stage registered adder
module tb_mcc_word_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] op_a, op_b;
    logic        op_cin;
    logic [4:0]  add_a, add_b;
    logic        add_cin;
    logic [4:0]  add_sum = '0;
    logic        add_cout = 1'b0;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_sum;
    logic        out_cout;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mcc_word_sequencer #(.SLICES(4), .SLICE_W(5), .ADD_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
    );

    always #5 clk = ~clk;

    // Adder stage: input register bank then output register bank.
    logic [4:0] a_d = '0, b_d = '0;
    logic       cin_d = 1'b0;
    always @(posedge clk) begin
        a_d <= add_a;
        b_d <= add_b;
        cin_d <= add_cin;
        {add_cout, add_sum} <= 6'(a_d) + 6'(b_d) + 6'(cin_d);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase -1 idle, 0..11 edges since accept, 12 result held.
    int          m_phase = -1;
    logic [31:0] m_a = 0, m_b = 0, m_c = 0;
    logic [19:0] m_sum = '0;
    logic        m_cout = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = -1;
            m_sum = '0;
            m_cout = 1'b0;
        end else if (m_phase == -1) begin
            if (in_valid) begin
                m_a = 32'(op_a);
                m_b = 32'(op_b);
                m_c = 32'(op_cin);
                m_phase = 0;
            end
        end else if (m_phase < 11) begin
            m_phase++;
        end else if (m_phase == 11) begin
            logic [31:0] t;
            t = m_a + m_b + m_c;
            m_sum = t[19:0];
            m_cout = t[20];
            m_phase = 12;
        end else if (out_ready) begin
            m_phase = -1;
        end
    end

    function automatic logic [31:0] carry_into(input int s);
        logic [31:0] mask, t;
        mask = (32'd1 << (5 * s)) - 32'd1;
        t = (m_a & mask) + (m_b & mask) + m_c;
        return (t >> (5 * s)) & 32'd1;
    endfunction

    always @(negedge clk) begin
        logic exec;
        int   s;
        exec = (m_phase >= 0) && (m_phase <= 11);
        s = exec ? m_phase / 3 : 0;
        chk("in_ready", 32'(in_ready), 32'(m_phase == -1));
        chk("busy", 32'(busy), 32'(m_phase >= 0));
        chk("out_valid", 32'(out_valid), 32'(m_phase == 12));
        chk("add_a", 32'(add_a), exec ? ((m_a >> (5 * s)) & 32'h1F) : 32'd0);
        chk("add_b", 32'(add_b), exec ? ((m_b >> (5 * s)) & 32'h1F) : 32'd0);
        chk("add_cin", 32'(add_cin), exec ? carry_into(s) : 32'd0);
        chk("out_cout", 32'(out_cout), 32'(m_cout));
        if (!exec) chk("out_sum", 32'(out_sum), 32'(m_sum));
    end

    task automatic start_op(input logic [19:0] a, input logic [19:0] b, input logic c);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        chk("idle_wait", 32'(in_ready), 32'd1);
        op_a = a; op_b = b; op_cin = c; in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        op_a = 20'($urandom); op_b = 20'($urandom); op_cin = 1'($urandom);
    endtask

    task automatic run_op(input logic [19:0] a, input logic [19:0] b, input logic c,
                          input logic [19:0] es, input logic ec, input int hold, input bit stab);
        int n = 0;
        logic [10:0] prev;
        start_op(a, b, c);
        prev = {add_a, add_b, add_cin};
        while (!out_valid && n < 40) begin
            @(posedge clk); #2;
            n++;
            if (stab && n < 12 && (n % 3) != 0) chk("add_stable", 32'({add_a, add_b, add_cin}), 32'(prev));
            prev = {add_a, add_b, add_cin};
        end
        chk("latency", n, 12);
        chk("res_sum", 32'(out_sum), 32'(es));
        chk("res_cout", 32'(out_cout), 32'(ec));
        chk("model_sum", 32'(m_sum), 32'(es));
        for (int i = 0; i < hold; i++) begin
            in_valid = (i % 2 == 0);
            @(posedge clk); #2;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_sum", 32'(out_sum), 32'(es));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;
        chk("ready_after", 32'(in_ready), 32'd1);
        chk("valid_after", 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; op_cin = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_zero", 32'({out_valid, busy, add_a, add_b, add_cin, out_cout, out_sum}), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #2;
        chk("idle_ready", 32'(in_ready), 32'd1);
        chk("idle_add", 32'({add_a, add_b, add_cin}), 32'd0);

        run_op(20'd1, 20'd2, 1'b0, 20'h00003, 1'b0, 0, 1'b0);
        run_op(20'hFFFFF, 20'h00001, 1'b0, 20'h00000, 1'b1, 0, 1'b0);
        run_op(20'h12345, 20'h0ABCD, 1'b1, 20'h1CF13, 1'b0, 5, 1'b1);

        start_op(20'h12345, 20'h0ABCD, 1'b1);
        repeat (7) begin
            @(posedge clk); #2;
        end
        rst_n = 1'b0;
        #1;
        chk("abort_zero", 32'({out_valid, busy, add_a, add_b, add_cin, out_cout, out_sum}), 32'd0);
        chk("abort_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b1;
        run_op(20'hFFFFF, 20'h00001, 1'b0, 20'h00000, 1'b1, 0, 1'b0);

        for (int k = 0; k < 25; k++) begin
            logic [19:0] a, b;
            logic        c;
            logic [20:0] t;
            a = 20'($urandom);
            b = 20'($urandom);
            c = 1'($urandom);
            t = 21'(a) + 21'(b) + 21'(c);
            run_op(a, b, c, t[19:0], t[20], int'($urandom_range(0, 3)), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
